// File: rtl/addr_trans_utlb_pkg.sv
// Shared types and DMW field positions for the front-end address translation stage.
package addr_trans_pkg;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    TLBR = 3'd1,
    PIL  = 3'd2,
    PIS  = 3'd3,
    PPI  = 3'd4,
    PME  = 3'd5
  } ecode_t;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } state_t;

  typedef struct packed {
    logic [19:0] vpn;
    logic [19:0] pfn;
    logic        v;
    logic        d;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        valid;
  } utlb_entry_t;

  localparam int DMW_VSEG_LO = 29;
  localparam int DMW_PSEG_LO = 25;
  localparam int DMW_MAT_LO  = 4;

  // Page checks shared by uTLB hits and main-TLB walk results.
  function automatic ecode_t page_check(input logic v, input logic d, input logic [1:0] pg_plv,
                                        input logic is_store, input logic [1:0] plv);
    if (!v) return is_store ? PIS : PIL;
    if (plv > pg_plv) return PPI;
    if (is_store && !d) return PME;
    return NONE;
  endfunction

endpackage

// File: rtl/addr_trans_utlb_if.sv
// Request/response and main-TLB refill signals of the translation stage.
interface addr_trans_utlb_if
  import addr_trans_pkg::*;
#(parameter int PALEN = 32) ();
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_vaddr;
  logic             req_is_store;
  logic             resp_valid;
  logic [PALEN-1:0] resp_paddr;
  logic [1:0]       resp_mat;
  logic             resp_is_dmw;
  logic             resp_exc;
  ecode_t           resp_ecode;
  logic             tlb_req_valid;
  logic [19:0]      tlb_req_vpn;
  logic             tlb_resp_valid;
  logic             tlb_resp_found;
  logic             tlb_resp_v;
  logic             tlb_resp_d;
  logic [1:0]       tlb_resp_plv;
  logic [1:0]       tlb_resp_mat;
  logic [19:0]      tlb_resp_pfn;

  modport master (
    output req_valid, req_vaddr, req_is_store,
    input  req_ready, resp_valid, resp_paddr, resp_mat, resp_is_dmw, resp_exc, resp_ecode,
    input  tlb_req_valid, tlb_req_vpn,
    output tlb_resp_valid, tlb_resp_found, tlb_resp_v, tlb_resp_d, tlb_resp_plv,
    output tlb_resp_mat, tlb_resp_pfn
  );

  modport slave (
    input  req_valid, req_vaddr, req_is_store,
    output req_ready, resp_valid, resp_paddr, resp_mat, resp_is_dmw, resp_exc, resp_ecode,
    output tlb_req_valid, tlb_req_vpn,
    input  tlb_resp_valid, tlb_resp_found, tlb_resp_v, tlb_resp_d, tlb_resp_plv,
    input  tlb_resp_mat, tlb_resp_pfn
  );
endinterface

// File: rtl/addr_trans_utlb_entry_array.sv
// Fully-associative uTLB storage: parallel lookup, fill (free slot first, else round robin), flush.
module utlb_entry_array
  import addr_trans_pkg::*;
#(parameter int ENTRIES = 4)
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [19:0] lookup_vpn,
  output logic        hit,
  output logic [19:0] hit_pfn,
  output logic        hit_v,
  output logic        hit_d,
  output logic [1:0]  hit_plv,
  output logic [1:0]  hit_mat,
  input  logic        fill_en,
  input  utlb_entry_t fill_entry,
  input  logic        flush
);
  localparam int IW = $clog2(ENTRIES);

  utlb_entry_t          ent [ENTRIES];
  logic [ENTRIES-1:0]   hit_onehot;
  utlb_entry_t          hit_entry;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        fill_idx;
  logic                 any_free;

  always_comb begin
    hit_entry = '0;
    for (int i = 0; i < ENTRIES; i++)
      hit_onehot[i] = ent[i].valid && (ent[i].vpn == lookup_vpn);
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (hit_onehot[i]) hit_entry = ent[i];
  end

  assign hit     = |hit_onehot;
  assign hit_pfn = hit_entry.pfn;
  assign hit_v   = hit_entry.v;
  assign hit_d   = hit_entry.d;
  assign hit_plv = hit_entry.plv;
  assign hit_mat = hit_entry.mat;

  always_comb begin
    any_free = 1'b0;
    fill_idx = rr_ptr;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!ent[i].valid) begin
        any_free = 1'b1;
        fill_idx = IW'(i);
      end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
      rr_ptr <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) ent[i].valid <= 1'b0;
    end else if (fill_en) begin
      ent[fill_idx] <= fill_entry;
      if (!any_free) rr_ptr <= rr_ptr + IW'(1);
    end
  end
endmodule

// File: rtl/addr_trans_utlb.sv
// Virtual-to-physical translation: direct mode, prioritised DMW windows, then uTLB with main-TLB refill.
module addr_trans_utlb
  import addr_trans_pkg::*;
#(
  parameter int NUM_DMW      = 2,
  parameter int UTLB_ENTRIES = 4,
  parameter int PALEN        = 32
)
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   csr_da,
  input  logic                   csr_pg,
  input  logic [1:0]             csr_plv,
  input  logic [1:0]             csr_datm,
  input  logic [32*NUM_DMW-1:0]  csr_dmw,
  input  logic                   utlb_flush,
  addr_trans_utlb_if.slave       bus
);
  state_t           state, state_nxt;
  logic [11:0]      lat_off;
  logic             lat_store;
  logic [1:0]       lat_plv;
  logic             flush_seen;
  logic             resp_valid_q, resp_valid_d;
  logic [PALEN-1:0] resp_paddr_q, resp_paddr_d;
  logic [1:0]       resp_mat_q, resp_mat_d;
  logic             resp_is_dmw_q, resp_is_dmw_d;
  logic             resp_exc_q, resp_exc_d;
  ecode_t           resp_ecode_q, resp_ecode_d;
  logic             tlb_req_valid_q;
  logic [19:0]      tlb_req_vpn_q;
  logic             accept, direct, dmw_hit, miss, fill_en;
  logic [31:0]      dmw_paddr;
  logic [1:0]       dmw_mat;
  logic             u_hit, u_v, u_d;
  logic [19:0]      u_pfn;
  logic [1:0]       u_plv, u_mat;
  ecode_t           hit_ec, walk_ec;
  utlb_entry_t      fill_entry;
  logic             unused_dmw_bits;

  assign unused_dmw_bits = ^csr_dmw;
  assign accept = bus.req_valid && (state == IDLE);
  assign direct = csr_da && !csr_pg;

  // Loop runs high to low so the lowest matching window wins.
  always_comb begin
    dmw_hit   = 1'b0;
    dmw_paddr = '0;
    dmw_mat   = '0;
    for (int i = NUM_DMW - 1; i >= 0; i--) begin
      if (csr_dmw[32*i + DMW_VSEG_LO +: 3] == bus.req_vaddr[31:29] && csr_dmw[32*i + int'(csr_plv)]) begin
        dmw_hit   = 1'b1;
        dmw_paddr = {csr_dmw[32*i + DMW_PSEG_LO +: 3], bus.req_vaddr[28:0]};
        dmw_mat   = csr_dmw[32*i + DMW_MAT_LO +: 2];
      end
    end
  end

  utlb_entry_array #(.ENTRIES(UTLB_ENTRIES)) u_array (
    .clk        (clk),
    .resetn     (resetn),
    .lookup_vpn (bus.req_vaddr[31:12]),
    .hit        (u_hit),
    .hit_pfn    (u_pfn),
    .hit_v      (u_v),
    .hit_d      (u_d),
    .hit_plv    (u_plv),
    .hit_mat    (u_mat),
    .fill_en    (fill_en),
    .fill_entry (fill_entry),
    .flush      (utlb_flush)
  );

  assign hit_ec  = page_check(u_v, u_d, u_plv, bus.req_is_store, csr_plv);
  assign walk_ec = bus.tlb_resp_found ?
                   page_check(bus.tlb_resp_v, bus.tlb_resp_d, bus.tlb_resp_plv, lat_store, lat_plv) : TLBR;
  assign fill_entry = '{vpn: tlb_req_vpn_q, pfn: bus.tlb_resp_pfn, v: bus.tlb_resp_v, d: bus.tlb_resp_d,
                        plv: bus.tlb_resp_plv, mat: bus.tlb_resp_mat, valid: 1'b1};

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    resp_valid_d  = 1'b0;
    resp_paddr_d  = resp_paddr_q;
    resp_mat_d    = resp_mat_q;
    resp_is_dmw_d = resp_is_dmw_q;
    resp_exc_d    = resp_exc_q;
    resp_ecode_d  = resp_ecode_q;
    miss          = 1'b0;
    fill_en       = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        if (direct) begin
          resp_valid_d = 1'b1; resp_paddr_d = PALEN'(bus.req_vaddr); resp_mat_d = csr_datm;
          resp_is_dmw_d = 1'b0; resp_exc_d = 1'b0; resp_ecode_d = NONE;
        end else if (dmw_hit) begin
          resp_valid_d = 1'b1; resp_paddr_d = PALEN'(dmw_paddr); resp_mat_d = dmw_mat;
          resp_is_dmw_d = 1'b1; resp_exc_d = 1'b0; resp_ecode_d = NONE;
        end else if (u_hit) begin
          resp_valid_d = 1'b1; resp_paddr_d = PALEN'({u_pfn, bus.req_vaddr[11:0]});
          resp_is_dmw_d = 1'b0; resp_exc_d = (hit_ec != NONE); resp_ecode_d = hit_ec;
          resp_mat_d = (hit_ec != NONE) ? 2'b00 : u_mat;
        end else begin
          miss      = 1'b1;
          state_nxt = WALK;
        end
      end
      WALK: if (bus.tlb_resp_valid) begin
        state_nxt     = IDLE;
        resp_valid_d  = 1'b1;
        resp_paddr_d  = PALEN'({bus.tlb_resp_pfn, lat_off});
        resp_is_dmw_d = 1'b0;
        resp_exc_d    = (walk_ec != NONE);
        resp_ecode_d  = walk_ec;
        resp_mat_d    = (walk_ec != NONE) ? 2'b00 : bus.tlb_resp_mat;
        fill_en       = bus.tlb_resp_found && bus.tlb_resp_v && !utlb_flush && !flush_seen;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp_valid_q <= 1'b0; resp_paddr_q <= '0; resp_mat_q <= '0; resp_is_dmw_q <= 1'b0;
      resp_exc_q <= 1'b0; resp_ecode_q <= NONE; tlb_req_valid_q <= 1'b0; tlb_req_vpn_q <= '0;
      lat_off <= '0; lat_store <= 1'b0; lat_plv <= '0; flush_seen <= 1'b0;
    end else begin
      resp_valid_q  <= resp_valid_d;
      resp_paddr_q  <= resp_paddr_d;
      resp_mat_q    <= resp_mat_d;
      resp_is_dmw_q <= resp_is_dmw_d;
      resp_exc_q    <= resp_exc_d;
      resp_ecode_q  <= resp_ecode_d;
      if (accept) begin
        lat_off    <= bus.req_vaddr[11:0];
        lat_store  <= bus.req_is_store;
        lat_plv    <= csr_plv;
        flush_seen <= 1'b0;
      end else if (state == WALK && utlb_flush) begin
        flush_seen <= 1'b1;
      end
      if (miss) begin
        tlb_req_valid_q <= 1'b1;
        tlb_req_vpn_q   <= bus.req_vaddr[31:12];
      end else if (state == WALK && bus.tlb_resp_valid) begin
        tlb_req_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready     = (state == IDLE);
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_paddr    = resp_paddr_q;
  assign bus.resp_mat      = resp_mat_q;
  assign bus.resp_is_dmw   = resp_is_dmw_q;
  assign bus.resp_exc      = resp_exc_q;
  assign bus.resp_ecode    = resp_ecode_q;
  assign bus.tlb_req_valid = tlb_req_valid_q;
  assign bus.tlb_req_vpn   = tlb_req_vpn_q;
endmodule

// File: tb/tb_addr_trans_utlb.sv
// Vector-table bench for addr_trans_utlb with a response scoreboard and a scripted main-TLB responder.
module tb_addr_trans_utlb;
  import addr_trans_pkg::*;

  typedef struct packed {
    logic        da, pg;
    logic [1:0]  plv, datm;
    logic [63:0] dmw;
    logic [31:0] vaddr;
    logic        store, flush_acc, walk, flush_walk;
    logic [3:0]  dly;
    logic        found, v, d;
    logic [1:0]  tplv, tmat;
    logic [19:0] pfn;
    logic [31:0] e_paddr;
    logic [1:0]  e_mat;
    logic        e_dmw, e_exc;
    ecode_t      e_ec;
  } vec_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic [1:0]  mat;
    logic        is_dmw, exc;
    ecode_t      ec;
  } exp_t;

  localparam logic [63:0] Z    = 64'h0;
  localparam logic [63:0] DMWA = 64'hA0000011_00000001;
  localparam logic [63:0] DMWP = 64'hA0000011_A2000001;
  localparam int NV = 25;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic csr_da = 1'b0, csr_pg = 1'b0, utlb_flush = 1'b0;
  logic [1:0] csr_plv = '0, csr_datm = '0;
  logic [63:0] csr_dmw = '0;
  int n_vec = 0, n_bad = 0;
  exp_t sb[$];
  vec_t vecs[NV];
  vec_t post_rst;

  addr_trans_utlb_if #(.PALEN(32)) bus ();

  addr_trans_utlb #(.NUM_DMW(2), .UTLB_ENTRIES(4), .PALEN(32)) dut (
    .clk(clk), .resetn(resetn), .csr_da(csr_da), .csr_pg(csr_pg), .csr_plv(csr_plv),
    .csr_datm(csr_datm), .csr_dmw(csr_dmw), .utlb_flush(utlb_flush), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'(bus.resp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_exc", 32'(bus.resp_exc), 32'(e.exc));
        chk("resp_ecode", 32'(bus.resp_ecode), 32'(e.ec));
        chk("resp_mat", 32'(bus.resp_mat), 32'(e.mat));
        chk("resp_is_dmw", 32'(bus.resp_is_dmw), 32'(e.is_dmw));
        if (!e.exc) chk("resp_paddr", bus.resp_paddr, e.paddr);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    exp_t e;
    int t;
    e = '{paddr: v.e_paddr, mat: v.e_mat, is_dmw: v.e_dmw, exc: v.e_exc, ec: v.e_ec};
    sb.push_back(e);
    @(negedge clk);
    csr_da = v.da; csr_pg = v.pg; csr_plv = v.plv; csr_datm = v.datm; csr_dmw = v.dmw;
    bus.req_vaddr = v.vaddr; bus.req_is_store = v.store; utlb_flush = v.flush_acc;
    bus.req_valid = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; utlb_flush = 1'b0;
    chk("hit_latency", 32'(bus.resp_valid), 32'(!v.walk));
    chk("tlb_req_valid", 32'(bus.tlb_req_valid), 32'(v.walk));
    if (v.walk) begin
      chk("tlb_req_vpn", 32'(bus.tlb_req_vpn), 32'(v.vaddr[31:12]));
      // Request state must have been latched: disturb the live CSRs.
      csr_plv = ~v.plv; csr_da = 1'b1; csr_pg = 1'b0;
      if (v.flush_walk) begin
        @(negedge clk) utlb_flush = 1'b1;
        @(negedge clk) utlb_flush = 1'b0;
      end
      repeat (int'(v.dly)) @(negedge clk);
      chk("walk_hold", 32'(bus.tlb_req_valid), 32'd1);
      bus.tlb_resp_found = v.found; bus.tlb_resp_v = v.v; bus.tlb_resp_d = v.d;
      bus.tlb_resp_plv = v.tplv; bus.tlb_resp_mat = v.tmat; bus.tlb_resp_pfn = v.pfn;
      bus.tlb_resp_valid = 1'b1;
      @(posedge clk); #1;
      bus.tlb_resp_valid = 1'b0;
      chk("walk_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("walk_req_drop", 32'(bus.tlb_req_valid), 32'd0);
    end
    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("resp_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    //         da pg pl dm dmw   vaddr         st fa wk fw dly fd v d tpl tmat pfn        e_paddr       em ed ex ec
    vecs[0]  = '{1,0,0,2,Z,   32'h1C000100,0,0,0,0,0, 0,0,0,0,0,20'h00000,32'h1C000100,2,0,0,NONE};
    vecs[1]  = '{1,0,0,3,DMWA,32'hA0000040,0,0,0,0,0, 0,0,0,0,0,20'h00000,32'hA0000040,3,0,0,NONE};
    vecs[2]  = '{0,1,0,0,DMWA,32'hA0000040,0,0,0,0,0, 0,0,0,0,0,20'h00000,32'h00000040,1,1,0,NONE};
    vecs[3]  = '{0,1,0,0,DMWP,32'hA0000040,0,0,0,0,0, 0,0,0,0,0,20'h00000,32'h20000040,0,1,0,NONE};
    vecs[4]  = '{0,1,3,0,DMWA,32'hA0000040,0,0,1,0,2, 1,1,1,3,1,20'h00ABC,32'h00ABC040,1,0,0,NONE};
    vecs[5]  = '{0,1,3,0,Z,   32'h00401234,0,0,1,0,3, 1,1,1,3,1,20'h12345,32'h12345234,1,0,0,NONE};
    vecs[6]  = '{0,1,3,0,Z,   32'h00401FFC,0,0,0,0,0, 0,0,0,0,0,20'h00000,32'h12345FFC,1,0,0,NONE};
    vecs[7]  = '{0,1,3,0,Z,   32'h00401008,1,0,0,0,0, 0,0,0,0,0,20'h00000,32'h12345008,1,0,0,NONE};
    vecs[8]  = '{0,1,0,0,Z,   32'h00402000,0,0,1,0,1, 0,0,0,0,0,20'h00000,32'h00000000,0,0,1,TLBR};
    vecs[9]  = '{0,1,0,0,Z,   32'h00402010,0,0,1,0,0, 1,1,0,0,2,20'h55555,32'h55555010,2,0,0,NONE};
    vecs[10] = '{0,1,0,0,Z,   32'h00402020,1,0,0,0,0, 0,0,0,0,0,20'h00000,32'h00000000,0,0,1,PME};
    vecs[11] = '{0,1,3,0,Z,   32'h00402020,0,0,0,0,0, 0,0,0,0,0,20'h00000,32'h00000000,0,0,1,PPI};
    vecs[12] = '{0,1,0,0,Z,   32'h00402024,0,0,0,0,0, 0,0,0,0,0,20'h00000,32'h55555024,2,0,0,NONE};
    vecs[13] = '{0,1,0,0,Z,   32'h00403000,1,0,1,0,1, 1,0,1,3,1,20'h00000,32'h00000000,0,0,1,PIS};
    vecs[14] = '{0,1,0,0,Z,   32'h00404000,0,0,1,0,1, 1,0,1,3,1,20'h00000,32'h00000000,0,0,1,PIL};
    vecs[15] = '{0,1,0,0,Z,   32'h00403000,0,0,1,0,0, 1,1,1,3,3,20'h03333,32'h03333000,3,0,0,NONE};
    vecs[16] = '{0,1,3,0,Z,   32'h00405000,0,0,1,0,2, 1,1,1,0,1,20'h0AAAA,32'h00000000,0,0,1,PPI};
    vecs[17] = '{0,1,0,0,Z,   32'h00405000,0,0,0,0,0, 0,0,0,0,0,20'h00000,32'h0AAAA000,1,0,0,NONE};
    vecs[18] = '{0,1,3,0,DMWA,32'hA0000040,0,0,1,0,1, 1,1,1,3,1,20'h00ABC,32'h00ABC040,1,0,0,NONE};
    vecs[19] = '{0,1,0,0,Z,   32'h00402020,0,0,0,0,0, 0,0,0,0,0,20'h00000,32'h55555020,2,0,0,NONE};
    vecs[20] = '{0,1,0,0,Z,   32'h00407000,0,0,1,1,1, 1,1,1,0,1,20'h07777,32'h07777000,1,0,0,NONE};
    vecs[21] = '{0,1,0,0,Z,   32'h00402020,0,0,1,0,0, 1,1,0,0,2,20'h55555,32'h55555020,2,0,0,NONE};
    vecs[22] = '{0,1,0,0,Z,   32'h00407000,0,0,1,0,0, 1,1,1,0,1,20'h07777,32'h07777000,1,0,0,NONE};
    vecs[23] = '{0,1,0,0,Z,   32'h00407ABC,0,1,0,0,0, 0,0,0,0,0,20'h00000,32'h07777ABC,1,0,0,NONE};
    vecs[24] = '{0,1,0,0,Z,   32'h00407ABC,0,0,1,0,0, 1,1,1,0,1,20'h07777,32'h07777ABC,1,0,0,NONE};
    post_rst = '{0,1,0,0,Z,   32'h00407ABC,0,0,1,0,1, 1,1,1,0,1,20'h07777,32'h07777ABC,1,0,0,NONE};

    bus.req_valid = 1'b0; bus.req_vaddr = '0; bus.req_is_store = 1'b0;
    bus.tlb_resp_valid = 1'b0; bus.tlb_resp_found = 1'b0; bus.tlb_resp_v = 1'b0;
    bus.tlb_resp_d = 1'b0; bus.tlb_resp_plv = '0; bus.tlb_resp_mat = '0; bus.tlb_resp_pfn = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_paddr", bus.resp_paddr, 32'd0);
    chk("rst_resp_mat", 32'(bus.resp_mat), 32'd0);
    chk("rst_resp_is_dmw", 32'(bus.resp_is_dmw), 32'd0);
    chk("rst_resp_exc", 32'(bus.resp_exc), 32'd0);
    chk("rst_resp_ecode", 32'(bus.resp_ecode), 32'(NONE));
    chk("rst_tlb_req_valid", 32'(bus.tlb_req_valid), 32'd0);
    chk("rst_tlb_req_vpn", 32'(bus.tlb_req_vpn), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk) resetn = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Reset in the middle of a walk: no response, request dropped, uTLB emptied.
    @(negedge clk);
    csr_da = 1'b0; csr_pg = 1'b1; csr_plv = 2'd0; csr_dmw = Z;
    bus.req_vaddr = 32'h00409000; bus.req_is_store = 1'b0; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rstwalk_req_valid", 32'(bus.tlb_req_valid), 32'd1);
    @(negedge clk) resetn = 1'b0;
    @(posedge clk); #1;
    chk("rstwalk_req_drop", 32'(bus.tlb_req_valid), 32'd0);
    chk("rstwalk_no_resp", 32'(bus.resp_valid), 32'd0);
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstwalk_quiet", 32'(bus.resp_valid | bus.tlb_req_valid), 32'd0);
    end
    run_vec(post_rst);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/addr_trans_utlb.md
Name: addr_trans_utlb

Overview:
- Next-generation virtual-to-physical translation stage for the LoongArch-32 pipeline front end (IF or MEM).
- Generalises direct and DMW translation to NUM_DMW windows with defined lowest-index priority.
- Adds a fully-associative micro-TLB (uTLB) of UTLB_ENTRIES 4 KB entries, refilled from the main TLB via a request/response handshake, and produces page exceptions.
- Registered request/response interface; 1-cycle latency on direct/DMW/uTLB hit, variable latency on a miss.

Parameters:
- NUM_DMW, 2, number of direct-mapped windows (1..4).
- UTLB_ENTRIES, 4, uTLB depth (power of 2, 2..16).
- PALEN, 32, physical address width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- req_valid  in  1  translation request
- req_ready  out  1  high only in IDLE
- req_vaddr  in  32  virtual address
- req_is_store  in  1  store access (dirty check)
- csr_da, csr_pg  in  1 each  CRMD.DA / CRMD.PG
- csr_plv  in  2  current privilege level
- csr_datm  in  2  MAT used in direct mode
- csr_dmw  in  32*NUM_DMW  DMW registers, window i at [32*i+:32]
- utlb_flush  in  1  invalidate all uTLB entries (TLBWR/TLBFILL/INVTLB/ASID write)
- resp_valid  out  1  one-cycle result pulse; consumer always accepts
- resp_paddr  out  PALEN  physical address
- resp_mat  out  2  memory access type
- resp_is_dmw  out  1  translated by a DMW
- resp_exc  out  1  exception
- resp_ecode  out  3  addr_trans_pkg::ecode_t: NONE, TLBR, PIL, PIS, PPI, PME
- tlb_req_valid  out  1  held high in WALK
- tlb_req_vpn  out  20  latched vaddr[31:12]
- tlb_resp_valid  in  1  main-TLB result, single-cycle, only while tlb_req_valid is high
- tlb_resp_found, tlb_resp_v, tlb_resp_d  in  1 each
- tlb_resp_plv  in  2
- tlb_resp_mat  in  2
- tlb_resp_pfn  in  20

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE; all entries invalid; rr_ptr=0; resp_valid=0; resp_paddr=0; resp_mat=0; resp_is_dmw=0; resp_exc=0; resp_ecode=NONE; tlb_req_valid=0; tlb_req_vpn=0. Reset during WALK abandons the walk with no response.
- Accept when req_valid & req_ready at edge T. vaddr, is_store and plv are latched; CSR changes after T do not affect the request.
- Translation priority at accept:
  1. DA&~PG: paddr=vaddr, mat=csr_datm.
  2. Else the lowest-index window i with dmw[i][31:29]==vaddr[31:29] and dmw[i][plv] set: paddr={dmw[i][27:25],vaddr[28:0]}, mat=dmw[i][5:4], is_dmw=1.
  3. Else uTLB lookup on vaddr[31:12].
- Cases 1, 2 and uTLB hit: response registered, resp_valid=1 at T+1, state stays IDLE.
- Hit checks, in priority order:
  - entry.v=0: PIS if store, else PIL.
  - plv > entry.plv: PPI.
  - store & ~entry.d: PME.
  - Otherwise paddr={pfn,vaddr[11:0]}, mat=entry.mat.
  - On exception, paddr is don't-care and mat=0.
- Miss: state→WALK at T+1; tlb_req_valid=1 and tlb_req_vpn=latched VPN until tlb_resp_valid.
- In WALK, on tlb_resp_valid:
  - Response registered (resp_valid next cycle); state→IDLE.
  - Exception checks as for a hit, with ~found → TLBR first.
  - Fill only when found & v & no utlb_flush that cycle and no flush seen during the walk.
  - Fill target: lowest-index invalid entry; if none, entry rr_ptr, then rr_ptr increments modulo UTLB_ENTRIES.
- utlb_flush: clears all valid bits next edge. A flush in the same cycle as an accept does not block that lookup. A flush during WALK suppresses the pending fill; the response is still delivered.
- A new request may be accepted in the same cycle resp_valid is high.
- Multiple hitting entries must not occur; uTLB fills only follow misses.

Decomposition:
- Package addr_trans_pkg: ecode_t enum; utlb_entry_t struct {vpn[19:0], pfn[19:0], v, d, plv[1:0], mat[1:0], valid}; state_t enum {IDLE, WALK}; DMW field constants (VSEG 31:29, PSEG 27:25, MAT 5:4).
- One sub-module, utlb_entry_array: storage, parallel compare, hit index/one-hot, fill and flush, rr_ptr.

Test Plan:
- DA=1,PG=0, vaddr 0x1C00_0100 → resp at T+1: paddr 0x1C00_0100, mat=csr_datm, is_dmw=0.
- PG=1, dmw0=0x0000_0001 (no match), dmw1=0xA000_0011 (vseg 5→pseg 0, PLV0, MAT1), vaddr 0xA000_0040 at plv0 → paddr 0x0000_0040, mat=1, is_dmw=1. Same address at plv3 → uTLB miss, WALK.
- Miss on 0x0040_1234, tlb resp 3 cycles later with found=1, v=1, d=1, pfn=0x12345 → resp_paddr 0x1234_5234; repeated access hits with 1-cycle latency and tlb_req_valid stays 0.
- tlb_resp_found=0 → resp_exc=1, ecode=TLBR, no fill; cached entry with d=0 on a store → PME; plv3 against entry plv0 → PPI.
- Fill UTLB_ENTRIES+1 distinct pages → the (N+1)th replaces entry 0; access to page 0 misses again.
- utlb_flush during WALK → response delivered, subsequent same-page access misses. resetn=0 in WALK → no resp_valid, tlb_req_valid=0 next cycle.
